axis_frame_fifo: RTL and testbench
==================================

# axis_frame_fifo

Store-and-forward AXI-Stream frame FIFO for the Ethernet receive path, the parametrised successor of `axis_fifo`. It widens the data path with byte enables and commits a frame to the read side only once its `tlast` beat has been accepted. Frames flagged `bad_frame`, and frames that overflow the buffer, are discarded whole. It sits between the MAC receive stream, which cannot be back-pressured, and downstream packet processing.

## Interface
Parameters:
- `DATA_WIDTH`, 8: data width in bits; must be a multiple of 8.
- `KEEP_WIDTH`, `DATA_WIDTH/8`: byte-enable width.
- `DEPTH`, 16: buffer depth in beats; must be a power of 2 and at least 4.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous active-high reset.
- `s_axis_tdata`  in  DATA_WIDTH  write data.
- `s_axis_tkeep`  in  KEEP_WIDTH  write byte enables; stored and forwarded unmodified.
- `s_axis_tvalid`  in  1  write beat valid.
- `s_axis_tlast`  in  1  last beat of the frame.
- `s_axis_tready`  out  1  constant 1 after reset; overflow is handled by dropping.
- `bad_frame`  in  1  sampled only on the `tlast` beat; 1 discards the frame.
- `m_axis_tdata`  out  DATA_WIDTH  read data.
- `m_axis_tkeep`  out  KEEP_WIDTH  read byte enables.
- `m_axis_tvalid`  out  1  read beat valid.
- `m_axis_tlast`  out  1  last beat of the frame on the read side.
- `m_axis_tready`  in  1  downstream ready.
- `status_good_frame`  out  1  one-cycle pulse when a frame is committed.
- `status_bad_frame`  out  1  one-cycle pulse when a frame is discarded by `bad_frame`.
- `status_overflow`  out  1  one-cycle pulse when a frame is discarded by overflow.

## Operation
- **Storage and pointers.** Each entry holds {tlast, tkeep, tdata}. Pointers are ADDR_W+1 bits wide, with ADDR_W = $clog2(DEPTH).
  - `wr_ptr_commit`: end of the last committed frame.
  - `wr_ptr_cur`: speculative write position within the current frame.
  - `rd_ptr`: read position.
- **Write FSM, state ACCEPT.**
  - On `s_axis_tvalid`, when `wr_ptr_cur - rd_ptr < DEPTH`: write the entry and increment `wr_ptr_cur`.
  - On `s_axis_tvalid` when the buffer is full: discard the beat and go to DROP. If that beat carries `tlast`, rewind immediately and stay in ACCEPT.
  - On the `tlast` beat with `bad_frame`=1: rewind `wr_ptr_cur` to `wr_ptr_commit` and pulse `status_bad_frame`.
  - On the `tlast` beat with `bad_frame`=0: set `wr_ptr_commit` to `wr_ptr_cur`+1 and pulse `status_good_frame`.
- **Write FSM, state DROP.**
  - Discard every beat.
  - On the `tlast` beat: rewind `wr_ptr_cur` to `wr_ptr_commit`, pulse `status_overflow`, and return to ACCEPT.
- **Priority.** If an overflow and `bad_frame`=1 occur in the same frame, report the frame as overflow only.
- **Oversized frames.** A frame longer than DEPTH always overflows and is dropped. A frame of exactly DEPTH beats is accepted when the buffer is empty.
- **Read side.**
  - The read side sees only committed data: readable when `rd_ptr != wr_ptr_commit`.
  - RAM read is synchronous and feeds a one-entry output register.
  - The output register holds a beat until `m_axis_tvalid && m_axis_tready`. It refills in the same cycle, so throughput is one beat per cycle.
- **Reset.** Reset clears all pointers, returns the FSM to ACCEPT and discards any partial frame. The RAM contents are not cleared.

## Timing
- **Reset values.** `m_axis_tvalid`, `m_axis_tlast`, `m_axis_tdata`, `m_axis_tkeep` and all status pulses are 0. `s_axis_tready` is 0 while `rst`=1 and 1 from the first edge after release.
- **Latency.** Take edge E as the edge that samples the `tlast` beat.
  - The commit and status pulse become visible after edge E.
  - The first beat of the frame appears on `m_axis_*` with `tvalid`=1 after edge E+2, provided the read side was idle.
- **Handshake.** `m_axis_*` is held stable while `m_axis_tvalid`=1 and `m_axis_tready`=0. `m_axis_tvalid` never deasserts without a completed transfer.
- **Simultaneous events.**
  - A read and a write in the same cycle are allowed.
  - A read that frees space at edge N is not visible to the full check until edge N+1.
  - A commit coinciding with a read of the last committed beat produces no gap beyond the 2-cycle latency.
- **Wrap-around.** Pointer arithmetic is modulo 2·DEPTH. Full is `wr_ptr_cur - rd_ptr == DEPTH`.

## Structure
- **Package `axis_frame_fifo_pkg`.** Holds the write FSM state enum `wr_state_t` (ACCEPT, DROP) and a function computing pointer occupancy.
- **Sub-module `axis_fifo_ram`.** A simple dual-port RAM with a synchronous read, parametrised in width and depth, holding the {tlast, tkeep, tdata} entries.

## Test plan
- **Single frame.** DATA_WIDTH=8, DEPTH=16, `m_axis_tready`=1; write 8-beat frame 00,01,02,03,0F,0C,0F,0C → the same 8 beats out, `tlast` on the 8th, `status_good_frame` pulses once, first output beat 2 cycles after `tlast`.
- **Bad frame between good frames.** Write frame AA..CD, then frame 00..0C with `bad_frame`=1 on its `tlast`, then AA..CD again → exactly 16 beats out (AA..CD twice), one `status_bad_frame` pulse.
- **Overflow.** `m_axis_tready`=0, buffer holds 12 committed beats; write an 8-beat frame → `status_overflow` on its `tlast`; with `tready` raised, only the 12 original beats emerge.
- **Oversized frame.** Empty buffer, 17-beat frame → dropped with `status_overflow`; a following 16-beat frame is accepted intact.
- **Back-pressure and wrap.** DATA_WIDTH=32, `tkeep`=4'b0111 on the last beat; random `m_axis_tready` over 50 frames crossing the pointer wrap → beats in order, `tkeep` preserved, output stable while stalled.
- **Reset mid-frame.** Assert `rst` after 3 beats of a frame → all outputs 0; after release, a new 4-beat frame is output intact with no residue from the aborted frame.

Source files
------------

// File: rtl/axis_frame_fifo_pkg.sv
// Shared types and helpers for the store-and-forward AXI-Stream frame FIFO.
// Combinational helpers only; no latency of their own.
// No flow control here; used by the write-side full check.
package axis_frame_fifo_pkg;

  // Write-side state: accepting beats of the current frame, or discarding
  // the remainder of a frame that no longer fits.
  typedef enum logic [0:0] {
    ACCEPT = 1'b0,
    DROP   = 1'b1
  } wr_state_t;

  localparam int OCC_W = 32;

  // Number of entries between two wrap-aware pointers of width ptr_w.
  // Pointers are passed zero-extended; the difference is taken modulo
  // 2**ptr_w so that the extra wrap bit resolves full versus empty.
  function automatic logic [OCC_W-1:0] ptr_occupancy(
    input logic [OCC_W-1:0] wr_ptr,
    input logic [OCC_W-1:0] rd_ptr,
    input int               ptr_w
  );
    logic [OCC_W-1:0] mask;
    mask = (OCC_W'(1) << ptr_w) - OCC_W'(1);
    return (wr_ptr - rd_ptr) & mask;
  endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port RAM holding {tlast, tkeep, tdata} frame FIFO entries.
// Write takes effect at the clock edge; read data is registered (1 cycle).
// No flow control: the read register holds its value while i_re is low.
module axis_fifo_ram
  import axis_frame_fifo_pkg::*;
#(
  parameter  int WIDTH  = 10,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Storage write port and registered read port; contents are never cleared.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axis_frame_fifo.sv
// Store-and-forward AXI-Stream frame FIFO; drops bad and overflowing frames whole.
// Latency: first beat valid 2 cycles after the edge that accepts tlast; 1 beat/cycle.
// Write side never stalls (tready=1, overflow drops); read side honours m_axis_tready.
module axis_frame_fifo
  import axis_frame_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  input  logic                  bad_frame,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  status_good_frame,
  output logic                  status_bad_frame,
  output logic                  status_overflow
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam int ENT_W  = 1 + KEEP_WIDTH + DATA_WIDTH;

  // Write-side state
  wr_state_t        r_state;
  logic [PTR_W-1:0] r_wr_ptr_cur;
  logic [PTR_W-1:0] r_wr_ptr_commit;
  logic             r_s_rdy;
  logic             r_good;
  logic             r_bad;
  logic             r_ovf;

  // Read-side state: r_pipe_vld marks valid data in the RAM read register,
  // r_m_vld/r_m_ent form the output register presented to the consumer.
  logic [PTR_W-1:0] r_rd_ptr;
  logic             r_pipe_vld;
  logic             r_m_vld;
  logic [ENT_W-1:0] r_m_ent;

  wr_state_t        w_state_nxt;
  logic [PTR_W-1:0] w_cur_nxt;
  logic [PTR_W-1:0] w_commit_nxt;
  logic             w_we;
  logic             w_good;
  logic             w_bad;
  logic             w_ovf;
  logic             w_beat;
  logic [OCC_W-1:0] w_occ;
  logic             w_full;
  logic             w_empty;
  logic             w_out_ld;
  logic             w_rd_en;
  logic [ENT_W-1:0] w_wdata;
  logic [ENT_W-1:0] w_ram_q;

  // Full is judged against the registered read pointer, so space freed by a
  // read only becomes usable on the following cycle.
  assign w_occ   = ptr_occupancy(OCC_W'(r_wr_ptr_cur), OCC_W'(r_rd_ptr), PTR_W);
  assign w_full  = (w_occ == OCC_W'(DEPTH));
  assign w_beat  = s_axis_tvalid && r_s_rdy;
  assign w_wdata = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};

  // Next-state and pointer updates for the write FSM.
  always_comb begin
    w_state_nxt  = r_state;
    w_cur_nxt    = r_wr_ptr_cur;
    w_commit_nxt = r_wr_ptr_commit;
    w_we         = 1'b0;
    w_good       = 1'b0;
    w_bad        = 1'b0;
    w_ovf        = 1'b0;
    case (r_state)
      ACCEPT: begin
        if (w_beat) begin
          if (w_full) begin
            if (s_axis_tlast) begin
              // Frame ends on the beat that did not fit: drop it right away.
              w_cur_nxt = r_wr_ptr_commit;
              w_ovf     = 1'b1;
            end else begin
              w_state_nxt = DROP;
            end
          end else begin
            w_we      = 1'b1;
            w_cur_nxt = r_wr_ptr_cur + PTR_W'(1);
            if (s_axis_tlast) begin
              if (bad_frame) begin
                w_cur_nxt = r_wr_ptr_commit;
                w_bad     = 1'b1;
              end else begin
                w_commit_nxt = r_wr_ptr_cur + PTR_W'(1);
                w_good       = 1'b1;
              end
            end
          end
        end
      end
      DROP: begin
        // bad_frame is ignored here: an overflowed frame reports overflow only.
        if (w_beat && s_axis_tlast) begin
          w_cur_nxt   = r_wr_ptr_commit;
          w_ovf       = 1'b1;
          w_state_nxt = ACCEPT;
        end
      end
      default: begin
        w_state_nxt = ACCEPT;
      end
    endcase
  end

  // Write FSM state, pointers and registered status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= ACCEPT;
      r_wr_ptr_cur    <= '0;
      r_wr_ptr_commit <= '0;
      r_s_rdy         <= 1'b0;
      r_good          <= 1'b0;
      r_bad           <= 1'b0;
      r_ovf           <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_wr_ptr_cur    <= w_cur_nxt;
      r_wr_ptr_commit <= w_commit_nxt;
      r_s_rdy         <= 1'b1;
      r_good          <= w_good;
      r_bad           <= w_bad;
      r_ovf           <= w_ovf;
    end
  end

  // Only committed data is visible to the reader. A RAM read is issued when
  // the read register is empty or is being moved into the output register.
  assign w_empty  = (r_rd_ptr == r_wr_ptr_commit);
  assign w_out_ld = !r_m_vld || m_axis_tready;
  assign w_rd_en  = !w_empty && (!r_pipe_vld || w_out_ld);

  axis_fifo_ram #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr_cur[ADDR_W-1:0]),
    .i_wdata (w_wdata),
    .i_re    (w_rd_en),
    .i_raddr (r_rd_ptr[ADDR_W-1:0]),
    .o_rdata (w_ram_q)
  );

  // Read pointer, RAM read-valid stage and output register with refill on pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr   <= '0;
      r_pipe_vld <= 1'b0;
      r_m_vld    <= 1'b0;
      r_m_ent    <= '0;
    end else begin
      if (w_rd_en) begin
        r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
        r_pipe_vld <= 1'b1;
      end else if (w_out_ld) begin
        r_pipe_vld <= 1'b0;
      end
      if (w_out_ld) begin
        r_m_vld <= r_pipe_vld;
        if (r_pipe_vld) begin
          r_m_ent <= w_ram_q;
        end
      end
    end
  end

  assign s_axis_tready     = r_s_rdy;
  assign m_axis_tvalid     = r_m_vld;
  assign m_axis_tdata      = r_m_ent[DATA_WIDTH-1:0];
  assign m_axis_tkeep      = r_m_ent[DATA_WIDTH +: KEEP_WIDTH];
  assign m_axis_tlast      = r_m_ent[ENT_W-1];
  assign status_good_frame = r_good;
  assign status_bad_frame  = r_bad;
  assign status_overflow   = r_ovf;

endmodule

// File: tb/tb_axis_frame_fifo.sv
// Scenario bench for axis_frame_fifo: expected beats queued as frames are driven,
// observed beats collected by a negedge monitor and compared per scenario.
module tb_axis_frame_fifo;

  localparam int DW    = 32;
  localparam int KW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [KW-1:0] s_axis_tkeep = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic          bad_frame = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready = 1'b0;
  logic          status_good_frame;
  logic          status_bad_frame;
  logic          status_overflow;

  axis_frame_fifo #(
    .DATA_WIDTH (DW),
    .KEEP_WIDTH (KW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tkeep      (s_axis_tkeep),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tlast      (s_axis_tlast),
    .s_axis_tready     (s_axis_tready),
    .bad_frame         (bad_frame),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tkeep      (m_axis_tkeep),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tlast      (m_axis_tlast),
    .m_axis_tready     (m_axis_tready),
    .status_good_frame (status_good_frame),
    .status_bad_frame  (status_bad_frame),
    .status_overflow   (status_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [36:0] q_exp[$];
  logic [31:0] fr_dat[$];
  int          obs_rd = 0;
  logic        rand_rdy = 1'b0;
  logic        fixed_rdy = 1'b1;

  // Written only by the monitor
  logic [36:0] q_obs[$];
  int          n_good = 0;
  int          n_bad = 0;
  int          n_ovf = 0;
  int          stab_viol = 0;
  int          rise_cyc = -1;
  logic        mon_stall = 1'b0;
  logic        mon_prev_vld = 1'b0;
  logic [36:0] mon_prev = '0;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #2;
    m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : fixed_rdy;
  end

  always @(negedge clk) begin
    if (rst) begin
      mon_stall    = 1'b0;
      mon_prev_vld = 1'b0;
    end else begin
      if (mon_stall && (!m_axis_tvalid || {m_axis_tlast, m_axis_tkeep, m_axis_tdata} !== mon_prev))
        stab_viol++;
      mon_stall = m_axis_tvalid && !m_axis_tready;
      mon_prev  = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
      if (m_axis_tvalid && !mon_prev_vld) rise_cyc = cyc;
      mon_prev_vld = m_axis_tvalid;
      if (m_axis_tvalid && m_axis_tready) q_obs.push_back({m_axis_tlast, m_axis_tkeep, m_axis_tdata});
      if (status_good_frame) n_good++;
      if (status_bad_frame)  n_bad++;
      if (status_overflow)   n_ovf++;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Drives fr_dat as one frame, beat per cycle; queues beats expected out.
  task automatic send_frame(input logic bad, input logic [3:0] last_keep,
                            input logic expect_out, output int e_cyc);
    for (int i = 0; i < fr_dat.size(); i++) begin
      s_axis_tdata  = fr_dat[i];
      s_axis_tlast  = (i == fr_dat.size() - 1);
      s_axis_tkeep  = s_axis_tlast ? last_keep : 4'hF;
      bad_frame     = s_axis_tlast & bad;
      s_axis_tvalid = 1'b1;
      if (expect_out) q_exp.push_back({s_axis_tlast, s_axis_tkeep, s_axis_tdata});
      @(posedge clk); #1;
    end
    e_cyc         = cyc;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    bad_frame     = 1'b0;
  endtask

  // Waits until as many beats were observed as are expected, then idles.
  task automatic drain(input int budget, output logic ok);
    int k = 0;
    while ((q_obs.size() - obs_rd) < q_exp.size() && k < budget) begin
      @(posedge clk);
      k++;
    end
    ok = ((q_obs.size() - obs_rd) >= q_exp.size());
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep,
         status_good_frame, status_bad_frame, status_overflow} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b l=%b d=%h k=%h st=%b%b%b required all 0",
               m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep,
               status_good_frame, status_bad_frame, status_overflow);
    end
    checks++;
    if (s_axis_tready !== 1'b0) begin
      errors++;
      $display("FAIL reset_tready got %b required 0", s_axis_tready);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (s_axis_tready !== 1'b1) begin
      errors++;
      $display("FAIL release_tready got %b required 1", s_axis_tready);
    end
  endtask

  task automatic test_single_frame();
    int e; int g0; logic ok; logic [36:0] ex; logic [36:0] got;
    fixed_rdy = 1'b1;
    repeat (3) @(posedge clk); #1;
    g0 = n_good;
    fr_dat = '{32'h00, 32'h01, 32'h02, 32'h03, 32'h0F, 32'h0C, 32'h0F, 32'h0C};
    send_frame(1'b0, 4'hF, 1'b1, e);
    checks++;
    if (status_good_frame !== 1'b1) begin
      errors++;
      $display("FAIL single_good_pulse got %b required 1 after tlast edge", status_good_frame);
    end
    drain(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_drain_timeout got %0d beats required %0d", q_obs.size() - obs_rd, q_exp.size()); end
    checks++;
    if (rise_cyc - e !== 2) begin
      errors++;
      $display("FAIL single_latency got %0d cycles required 2", rise_cyc - e);
    end
    while (q_exp.size() > 0 && obs_rd < q_obs.size()) begin
      ex = q_exp.pop_front(); got = q_obs[obs_rd]; obs_rd++;
      checks++;
      if (got !== ex) begin errors++; $display("FAIL single_beat got %h required %h", got, ex); end
    end
    checks++;
    if (q_exp.size() != 0 || obs_rd != q_obs.size() || n_good - g0 != 1) begin
      errors++;
      $display("FAIL single_counts missing %0d extra %0d good %0d required 0 0 1",
               q_exp.size(), q_obs.size() - obs_rd, n_good - g0);
    end
    q_exp.delete(); obs_rd = q_obs.size();
  endtask

  task automatic test_bad_frame();
    int e; int g0; int b0; int o0; logic ok; logic [36:0] ex; logic [36:0] got;
    g0 = n_good; b0 = n_bad; o0 = n_ovf;
    fr_dat = '{32'hAA, 32'hAB, 32'hAC, 32'hAD, 32'hBA, 32'hBB, 32'hCC, 32'hCD};
    send_frame(1'b0, 4'hF, 1'b1, e);
    fr_dat = '{32'h00, 32'h01, 32'h02, 32'h04, 32'h08, 32'h0A, 32'h0B, 32'h0C};
    send_frame(1'b1, 4'hF, 1'b0, e);
    checks++;
    if (status_bad_frame !== 1'b1) begin
      errors++;
      $display("FAIL bad_pulse got %b required 1 after tlast edge", status_bad_frame);
    end
    fr_dat = '{32'hAA, 32'hAB, 32'hAC, 32'hAD, 32'hBA, 32'hBB, 32'hCC, 32'hCD};
    send_frame(1'b0, 4'hF, 1'b1, e);
    drain(300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bad_drain_timeout got %0d beats required %0d", q_obs.size() - obs_rd, q_exp.size()); end
    while (q_exp.size() > 0 && obs_rd < q_obs.size()) begin
      ex = q_exp.pop_front(); got = q_obs[obs_rd]; obs_rd++;
      checks++;
      if (got !== ex) begin errors++; $display("FAIL bad_beat got %h required %h", got, ex); end
    end
    checks++;
    if (q_exp.size() != 0 || obs_rd != q_obs.size() || n_good - g0 != 2 || n_bad - b0 != 1 || n_ovf != o0) begin
      errors++;
      $display("FAIL bad_counts missing %0d extra %0d good %0d bad %0d ovf %0d required 0 0 2 1 0",
               q_exp.size(), q_obs.size() - obs_rd, n_good - g0, n_bad - b0, n_ovf - o0);
    end
    q_exp.delete(); obs_rd = q_obs.size();
  endtask

  task automatic test_overflow();
    int e; int g0; int o0; logic ok; logic [36:0] ex; logic [36:0] got;
    fixed_rdy = 1'b0;
    repeat (3) @(posedge clk); #1;
    g0 = n_good; o0 = n_ovf;
    fr_dat.delete();
    for (int i = 0; i < 12; i++) fr_dat.push_back(32'h10 + i);
    send_frame(1'b0, 4'hF, 1'b1, e);
    fr_dat.delete();
    for (int i = 0; i < 8; i++) fr_dat.push_back(32'h40 + i);
    send_frame(1'b0, 4'hF, 1'b0, e);
    checks++;
    if (status_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_pulse got %b required 1 after tlast edge", status_overflow);
    end
    fixed_rdy = 1'b1;
    drain(300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ovf_drain_timeout got %0d beats required %0d", q_obs.size() - obs_rd, q_exp.size()); end
    while (q_exp.size() > 0 && obs_rd < q_obs.size()) begin
      ex = q_exp.pop_front(); got = q_obs[obs_rd]; obs_rd++;
      checks++;
      if (got !== ex) begin errors++; $display("FAIL ovf_beat got %h required %h", got, ex); end
    end
    checks++;
    if (q_exp.size() != 0 || obs_rd != q_obs.size() || n_good - g0 != 1 || n_ovf - o0 != 1) begin
      errors++;
      $display("FAIL ovf_counts missing %0d extra %0d good %0d ovf %0d required 0 0 1 1",
               q_exp.size(), q_obs.size() - obs_rd, n_good - g0, n_ovf - o0);
    end
    q_exp.delete(); obs_rd = q_obs.size();
  endtask

  task automatic test_oversized();
    int e; int g0; int o0; logic ok; logic [36:0] ex; logic [36:0] got;
    g0 = n_good; o0 = n_ovf;
    fr_dat.delete();
    for (int i = 0; i < DEPTH + 1; i++) fr_dat.push_back(32'h100 + i);
    send_frame(1'b0, 4'hF, 1'b0, e);
    checks++;
    if (status_overflow !== 1'b1) begin
      errors++;
      $display("FAIL oversize_pulse got %b required 1 after tlast edge", status_overflow);
    end
    fr_dat.delete();
    for (int i = 0; i < DEPTH; i++) fr_dat.push_back(32'h200 + i);
    send_frame(1'b0, 4'h3, 1'b1, e);
    drain(300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL oversize_drain_timeout got %0d beats required %0d", q_obs.size() - obs_rd, q_exp.size()); end
    while (q_exp.size() > 0 && obs_rd < q_obs.size()) begin
      ex = q_exp.pop_front(); got = q_obs[obs_rd]; obs_rd++;
      checks++;
      if (got !== ex) begin errors++; $display("FAIL oversize_beat got %h required %h", got, ex); end
    end
    checks++;
    if (q_exp.size() != 0 || obs_rd != q_obs.size() || n_good - g0 != 1 || n_ovf - o0 != 1) begin
      errors++;
      $display("FAIL oversize_counts missing %0d extra %0d good %0d ovf %0d required 0 0 1 1",
               q_exp.size(), q_obs.size() - obs_rd, n_good - g0, n_ovf - o0);
    end
    q_exp.delete(); obs_rd = q_obs.size();
  endtask

  task automatic test_back_to_back();
    int e; int g0; int o0; int s0; int len; int k; logic ok; logic [36:0] ex; logic [36:0] got;
    g0 = n_good; o0 = n_ovf; s0 = stab_viol;
    rand_rdy = 1'b1;
    for (int f = 0; f < 50; f++) begin
      k = 0;
      while (q_exp.size() - (q_obs.size() - obs_rd) > 4 && k < 2000) begin
        @(posedge clk); #1;
        k++;
      end
      len = $urandom_range(1, 8);
      fr_dat.delete();
      for (int i = 0; i < len; i++) fr_dat.push_back({8'(f), 8'(i), 16'($urandom)});
      send_frame(1'b0, 4'b0111, 1'b1, e);
    end
    rand_rdy  = 1'b0;
    fixed_rdy = 1'b1;
    drain(2000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_drain_timeout got %0d beats required %0d", q_obs.size() - obs_rd, q_exp.size()); end
    while (q_exp.size() > 0 && obs_rd < q_obs.size()) begin
      ex = q_exp.pop_front(); got = q_obs[obs_rd]; obs_rd++;
      checks++;
      if (got !== ex) begin errors++; $display("FAIL b2b_beat got %h required %h", got, ex); end
    end
    checks++;
    if (q_exp.size() != 0 || obs_rd != q_obs.size() || n_good - g0 != 50 || n_ovf != o0) begin
      errors++;
      $display("FAIL b2b_counts missing %0d extra %0d good %0d ovf %0d required 0 0 50 0",
               q_exp.size(), q_obs.size() - obs_rd, n_good - g0, n_ovf - o0);
    end
    checks++;
    if (stab_viol - s0 != 0) begin
      errors++;
      $display("FAIL b2b_stall_stability got %0d changes while stalled required 0", stab_viol - s0);
    end
    q_exp.delete(); obs_rd = q_obs.size();
  endtask

  task automatic test_reset_mid_frame();
    int e; int g0; logic ok; logic [36:0] ex; logic [36:0] got;
    fixed_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_axis_tdata  = 32'hDEAD_0000 + i;
      s_axis_tkeep  = 4'hF;
      s_axis_tlast  = 1'b0;
      s_axis_tvalid = 1'b1;
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
    rst = 1'b1;
    #2;
    checks++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep, s_axis_tready,
         status_good_frame, status_bad_frame, status_overflow} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got v=%b l=%b d=%h k=%h rdy=%b required all 0",
               m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep, s_axis_tready);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    g0 = n_good;
    fr_dat = '{32'h5000_0001, 32'h5000_0002, 32'h5000_0003, 32'h5000_0004};
    send_frame(1'b0, 4'h1, 1'b1, e);
    drain(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL midreset_drain_timeout got %0d beats required %0d", q_obs.size() - obs_rd, q_exp.size()); end
    while (q_exp.size() > 0 && obs_rd < q_obs.size()) begin
      ex = q_exp.pop_front(); got = q_obs[obs_rd]; obs_rd++;
      checks++;
      if (got !== ex) begin errors++; $display("FAIL midreset_beat got %h required %h", got, ex); end
    end
    checks++;
    if (q_exp.size() != 0 || obs_rd != q_obs.size() || n_good - g0 != 1) begin
      errors++;
      $display("FAIL midreset_counts missing %0d extra %0d good %0d required 0 0 1",
               q_exp.size(), q_obs.size() - obs_rd, n_good - g0);
    end
    q_exp.delete(); obs_rd = q_obs.size();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_bad_frame();
    test_overflow();
    test_oversized();
    test_back_to_back();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
